// File: rtl/serial_rx.sv
// UART receiver: 8 data bits, LSB first, no parity, idle-high line.
// Each bit is sampled at its centre by a per-bit counter started at mid-start-bit.
module serial_rx #(
  parameter int inputFrequency = 25000000,
  parameter int baudRate       = 115200,
  parameter int baudGenWidth   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       overrun,
  output logic       frameError,
  output logic       busy
);

  localparam int BIT_PERIOD  = inputFrequency / baudRate;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [baudGenWidth-1:0] BIT_LAST  = baudGenWidth'(BIT_PERIOD - 1);
  localparam logic [baudGenWidth-1:0] HALF_LAST = baudGenWidth'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                  state;
  logic [baudGenWidth-1:0] cnt;
  logic [2:0]              bit_idx;
  logic [7:0]              shreg;
  logic                    rx_p0, rx_p1;
  logic                    rxS;

  // Stage p0/p1: two-flop synchroniser for the asynchronous line, idle value 1
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rxS  = rx_p1;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      dataReady  <= 1'b0;
      overrun    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameError <= 1'b0;
      if (read && dataReady) begin
        dataReady <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxS) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxS ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxS, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Leaving at mid-stop-bit lets a start bit right after one stop bit be caught
            if (rxS) begin
              data      <= shreg;
              dataReady <= 1'b1;
              overrun   <= dataReady && !read;
              state     <= S_IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxS) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: vector table, corner-case sequences and random frames
// checked against a frame-level model of the receiver's output register.
module tb_serial_rx;

  localparam int BP  = 217;
  localparam int HP  = 108;
  localparam int LAT = HP + 9 * BP + 3;

  logic       clk = 1'b0;
  logic       rst, rx, read;
  logic [7:0] data;
  logic       dataReady, overrun, frameError, busy;

  serial_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .read(read), .data(data),
    .dataReady(dataReady), .overrun(overrun), .frameError(frameError), .busy(busy)
  );

  always #20 clk = ~clk;

  int   cyc = 0;
  int   fe_cnt = 0, busy_cnt = 0, rise_cyc = 0;
  logic ready_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frameError) fe_cnt <= fe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (dataReady && !ready_q) rise_cyc <= cyc;
    ready_q <= dataReady;
  end

  int         nvec = 0, nerr = 0;
  logic [7:0] m_data;
  logic       m_ready, m_ovr;
  int         start_cyc;

  typedef struct {
    logic [7:0] val;
    int         period;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int p, input logic stop_lvl, input int nstop);
    start_cyc = cyc;
    rx = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(p);
    end
    rx = stop_lvl;
    tick(p * nstop);
    rx = 1'b1;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic rd);
    if (rd) m_ovr = 1'b0;
    else if (m_ready) m_ovr = 1'b1;
    m_data  = b;
    m_ready = 1'b1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    tick(1);
    read = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_data"}, data, m_data);
    chk({tag, "_ready"}, dataReady, m_ready);
    chk({tag, "_overrun"}, overrun, m_ovr);
  endtask

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, b0;
    logic [7:0] rb;
    int rp, rs, rr;

    tbl[0] = '{8'hA5, 217, 8'hA5, LAT};
    tbl[1] = '{8'h00, 217, 8'h00, LAT};
    tbl[2] = '{8'hFF, 217, 8'hFF, LAT};
    tbl[3] = '{8'h81, 217, 8'h81, LAT};
    tbl[4] = '{8'h5A, 210, 8'h5A, LAT};
    tbl[5] = '{8'hC3, 224, 8'hC3, LAT};

    rst = 1'b1; rx = 1'b1; read = 1'b0;
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset");
    chk("reset_fe", frameError, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // Single frames with read-back
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      send(tbl[i].val, tbl[i].period, 1'b1, 1);
      tick(2);
      chk("tbl_data", data, tbl[i].exp_data);
      chk("tbl_ready", dataReady, 1);
      chk("tbl_overrun", overrun, 0);
      chk("tbl_latency", rise_cyc - start_cyc, tbl[i].exp_lat);
      chk("tbl_fe", fe_cnt - fe0, 0);
      m_frame(tbl[i].val, 1'b0);
      pulse_read();
      chk("tbl_read_clear", dataReady, 0);
    end

    // Short low glitch on an idle line
    fe0 = fe_cnt; b0 = busy_cnt;
    rx = 1'b0;
    tick(50);
    rx = 1'b1;
    tick(300);
    chk("glitch_busy_cycles", busy_cnt - b0, HP);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_ready", dataReady, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // Break: zero byte with low stop bit, line held low
    fe0 = fe_cnt;
    fork
      send(8'h00, BP, 1'b0, 21);
      begin
        tick(20 * BP);
        chk("break_fe_mid", fe_cnt - fe0, 1);
        chk("break_ready_mid", dataReady, 0);
        chk("break_busy_mid", busy, 1);
        chk("break_data_mid", data, m_data);
      end
    join
    tick(2 * BP);
    chk("break_fe_after", fe_cnt - fe0, 1);
    chk("break_busy_after", busy, 0);
    send(8'h3C, BP, 1'b1, 1);
    m_frame(8'h3C, 1'b0);
    tick(2);
    chk_state("after_break");
    chk("after_break_fe", fe_cnt - fe0, 1);
    pulse_read();

    // Back-to-back bytes without reading
    send(8'h11, BP, 1'b1, 1);
    m_frame(8'h11, 1'b0);
    send(8'h22, BP, 1'b1, 1);
    m_frame(8'h22, 1'b0);
    tick(2);
    chk_state("b2b");
    pulse_read();
    chk("b2b_read_ready", dataReady, 0);
    chk("b2b_read_overrun", overrun, 0);

    // Read coinciding with the stop-bit sample of a new byte
    send(8'h55, BP, 1'b1, 1);
    m_frame(8'h55, 1'b0);
    send(8'h66, BP, 1'b1, 1);
    m_frame(8'h66, 1'b0);
    chk("coinc_pre_overrun", overrun, 1);
    fork
      send(8'h77, BP, 1'b1, 1);
      begin
        tick(LAT - 1);
        read = 1'b1;
        tick(1);
        read = 1'b0;
      end
    join
    m_frame(8'h77, 1'b1);
    tick(2);
    chk_state("coinc");
    pulse_read();

    // Reset in the middle of a frame
    send(8'h96, BP, 1'b1, 1);
    m_frame(8'h96, 1'b0);
    fork
      send(8'hF0, BP, 1'b1, 1);
      begin
        tick(1150);
        rst = 1'b1;
        tick(1);
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0;
        chk_state("midrst");
        chk("midrst_busy", busy, 0);
        chk("midrst_fe", frameError, 0);
        rst = 1'b0;
        b0 = busy_cnt;
      end
    join
    chk("midrst_no_restart", busy_cnt - b0, 0);
    send(8'h5A, 210, 1'b1, 1);
    m_frame(8'h5A, 1'b0);
    tick(2);
    chk_state("rate210");
    pulse_read();
    send(8'h5A, 224, 1'b1, 1);
    m_frame(8'h5A, 1'b0);
    tick(2);
    chk_state("rate224");
    pulse_read();

    // Random frames with random reads between them
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      rp = $urandom_range(212, 222);
      rs = $urandom_range(1, 2);
      rr = $urandom_range(0, 1);
      if (rr != 0) pulse_read();
      fe0 = fe_cnt;
      send(rb, rp, 1'b1, rs);
      m_frame(rb, 1'b0);
      tick(2);
      chk_state("rand");
      chk("rand_fe", fe_cnt - fe0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
